loadable_updown_counter: RTL and testbench

//   Parametrised successor to the team's 5-bit loadable counter. Adds up/down

---
 rtl/loadable_updown_counter_if.sv | 23 ++
 rtl/loadable_updown_counter.sv | 85 ++++++++
 tb/tb_loadable_updown_counter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/loadable_updown_counter_if.sv
// rtl/loadable_updown_counter_if.sv - control and status bundle for the loadable up/down counter
interface loadable_updown_counter_if #(
  parameter int unsigned WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             udf;

  modport master (
    output load, data_in, en, up,
    input  count, tc, ovf, udf
  );

  modport slave (
    input  load, data_in, en, up,
    output count, tc, ovf, udf
  );
endinterface

// File: rtl/loadable_updown_counter.sv
// rtl/loadable_updown_counter.sv - ranged up/down counter with clamped load, wrap/saturate ends and ovf/udf pulses
module loadable_updown_counter #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int unsigned RST_VAL  = 0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  loadable_updown_counter_if.slave   cnt_if
);
  // One extra bit keeps MAX_VAL = 2**WIDTH-1 from aliasing when compared or stepped.
  localparam logic [WIDTH:0]   MIN_X = (WIDTH + 1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   data_x;
  logic [WIDTH:0]   next_x;
  logic             at_max;
  logic             at_min;

  always_comb begin
    count_x = {1'b0, count_q};
    data_x  = {1'b0, cnt_if.data_in};
    at_max  = (count_x == MAX_X);
    at_min  = (count_x == MIN_X);
    next_x  = count_x;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;

    if (cnt_if.load) begin
      if (data_x > MAX_X) begin
        next_x = MAX_X;
      end else if (data_x < MIN_X) begin
        next_x = MIN_X;
      end else begin
        next_x = data_x;
      end
    end else if (cnt_if.en) begin
      if (cnt_if.up) begin
        if (at_max) begin
          ovf_d  = 1'b1;
          next_x = SATURATE ? MAX_X : MIN_X;
        end else begin
          next_x = count_x + ONE_X;
        end
      end else begin
        if (at_min) begin
          udf_d  = 1'b1;
          next_x = SATURATE ? MIN_X : MAX_X;
        end else begin
          next_x = count_x - ONE_X;
        end
      end
    end

    count_d = next_x[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_C;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // tc warns of the coming range-end event on the current edge; deliberately not gated by rst.
  assign cnt_if.tc    = cnt_if.en & ~cnt_if.load &
                        ((cnt_if.up & at_max) | (~cnt_if.up & at_min));
  assign cnt_if.count = count_q;
  assign cnt_if.ovf   = ovf_q;
  assign cnt_if.udf   = udf_q;
endmodule

// File: tb/tb_loadable_updown_counter.sv
// tb/tb_loadable_updown_counter.sv - three counter configurations driven in parallel and checked against a range model
module tb_loadable_updown_counter;
  logic       clk;
  logic       rst;
  logic       load;
  logic [4:0] data_in;
  logic       en;
  logic       up;

  int vectors     = 0;
  int miscompares = 0;

  // Config 0: defaults; config 1: 3..12 wrap, reset to 5; config 2: full range saturating.
  int cfg_min[3] = '{0, 3, 0};
  int cfg_max[3] = '{31, 12, 31};
  int cfg_rst[3] = '{0, 5, 0};
  bit cfg_sat[3] = '{1'b0, 1'b0, 1'b1};

  loadable_updown_counter_if #(.WIDTH(5)) if0 ();
  loadable_updown_counter_if #(.WIDTH(5)) if1 ();
  loadable_updown_counter_if #(.WIDTH(5)) if2 ();

  assign if0.load = load; assign if0.data_in = data_in; assign if0.en = en; assign if0.up = up;
  assign if1.load = load; assign if1.data_in = data_in; assign if1.en = en; assign if1.up = up;
  assign if2.load = load; assign if2.data_in = data_in; assign if2.en = en; assign if2.up = up;

  loadable_updown_counter #(.WIDTH(5)) dut0 (
    .clk(clk), .rst(rst), .cnt_if(if0)
  );
  loadable_updown_counter #(.WIDTH(5), .MIN_VAL(3), .MAX_VAL(12), .RST_VAL(5), .SATURATE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .cnt_if(if1)
  );
  loadable_updown_counter #(.WIDTH(5), .SATURATE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .cnt_if(if2)
  );

  logic [4:0] d_cnt [3];
  logic       d_tc  [3];
  logic       d_ovf [3];
  logic       d_udf [3];
  assign d_cnt[0] = if0.count; assign d_tc[0] = if0.tc; assign d_ovf[0] = if0.ovf; assign d_udf[0] = if0.udf;
  assign d_cnt[1] = if1.count; assign d_tc[1] = if1.tc; assign d_ovf[1] = if1.ovf; assign d_udf[1] = if1.udf;
  assign d_cnt[2] = if2.count; assign d_tc[2] = if2.tc; assign d_ovf[2] = if2.ovf; assign d_udf[2] = if2.udf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Range model: next count and event flags from the behavioural rules in plain integers.
  function automatic void model_next(input int cur, input bit r, input bit l, input int d,
                                     input bit e, input bit u, input int k,
                                     output int nxt, output bit o, output bit un);
    o   = 1'b0;
    un  = 1'b0;
    nxt = cur;
    if (r) begin
      nxt = cfg_rst[k];
    end else if (l) begin
      nxt = (d > cfg_max[k]) ? cfg_max[k] : (d < cfg_min[k]) ? cfg_min[k] : d;
    end else if (e && u) begin
      if (cur == cfg_max[k]) begin
        o   = 1'b1;
        nxt = cfg_sat[k] ? cfg_max[k] : cfg_min[k];
      end else begin
        nxt = cur + 1;
      end
    end else if (e) begin
      if (cur == cfg_min[k]) begin
        un  = 1'b1;
        nxt = cfg_sat[k] ? cfg_min[k] : cfg_max[k];
      end else begin
        nxt = cur - 1;
      end
    end
  endfunction

  int m_cnt [3] = '{0, 0, 0};
  bit m_ovf [3] = '{1'b0, 1'b0, 1'b0};
  bit m_udf [3] = '{1'b0, 1'b0, 1'b0};
  bit m_valid   = 1'b0;

  always @(posedge clk) begin
    int  nc;
    bit  no;
    bit  nu;
    bit  exp_tc;
    for (int k = 0; k < 3; k++) begin
      model_next(m_cnt[k], rst, load, int'(data_in), en, up, k, nc, no, nu);
      m_cnt[k] = nc;
      m_ovf[k] = no;
      m_udf[k] = nu;
    end
    if (rst) m_valid = 1'b1;
    #1;
    if (m_valid) begin
      for (int k = 0; k < 3; k++) begin
        exp_tc = en && !load && ((up && m_cnt[k] == cfg_max[k]) || (!up && m_cnt[k] == cfg_min[k]));
        chk($sformatf("model count cfg%0d", k), 32'(d_cnt[k]), 32'(m_cnt[k]));
        chk($sformatf("model tc cfg%0d", k), 32'(d_tc[k]), 32'(exp_tc));
        chk($sformatf("model ovf cfg%0d", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
        chk($sformatf("model udf cfg%0d", k), 32'(d_udf[k]), 32'(m_udf[k]));
      end
    end
  end

  task automatic step(input bit r, input bit l, input int d, input bit e, input bit u);
    @(negedge clk);
    rst     = r;
    load    = l;
    data_in = 5'(d);
    en      = e;
    up      = u;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; data_in = '0; en = 1'b0; up = 1'b1;

    // Reset, then three up-steps
    step(1, 0, 0, 0, 1);
    chk("t1 reset count cfg0", 32'(if0.count), 32'd0);
    chk("t1 reset count cfg1", 32'(if1.count), 32'd5);
    chk("t1 reset ovf cfg0", 32'(if0.ovf), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, 1);
      chk($sformatf("t1 count step%0d", i), 32'(if0.count), 32'(i));
    end
    chk("t1 ovf", 32'(if0.ovf), 32'd0);
    chk("t1 udf", 32'(if0.udf), 32'd0);

    // Load 27 with en high, climb to 31, wrap with ovf
    step(0, 1, 27, 1, 1);
    chk("t2 load count", 32'(if0.count), 32'd27);
    for (int i = 28; i <= 31; i++) begin
      step(0, 0, 0, 1, 1);
      chk($sformatf("t2 count %0d", i), 32'(if0.count), 32'(i));
    end
    chk("t2 tc at 31", 32'(if0.tc), 32'd1);
    step(0, 0, 0, 1, 1);
    chk("t2 wrap count", 32'(if0.count), 32'd0);
    chk("t2 wrap ovf", 32'(if0.ovf), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("t2 ovf one cycle", 32'(if0.ovf), 32'd0);

    // Narrow range 3..12: underflow wrap and clamped load
    step(0, 1, 4, 1, 0);
    chk("t3 load 4", 32'(if1.count), 32'd4);
    step(0, 0, 0, 1, 0);
    chk("t3 count 3", 32'(if1.count), 32'd3);
    chk("t3 tc at min", 32'(if1.tc), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("t3 wrap to 12", 32'(if1.count), 32'd12);
    chk("t3 udf", 32'(if1.udf), 32'd1);
    step(0, 1, 31, 1, 1);
    chk("t3 clamp load", 32'(if1.count), 32'd12);
    chk("t3 clamp no ovf", 32'(if1.ovf), 32'd0);
    chk("t3 clamp no udf", 32'(if1.udf), 32'd0);

    // Saturating config at the top end
    step(0, 1, 30, 1, 1);
    chk("t4 load 30", 32'(if2.count), 32'd30);
    step(0, 0, 0, 1, 1);
    chk("t4 reach 31", 32'(if2.count), 32'd31);
    chk("t4 no ovf reaching 31", 32'(if2.ovf), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1);
      chk($sformatf("t4 hold 31 #%0d", i), 32'(if2.count), 32'd31);
      chk($sformatf("t4 ovf pulse #%0d", i), 32'(if2.ovf), 32'd1);
    end
    step(0, 0, 0, 1, 0);
    chk("t4 down to 30", 32'(if2.count), 32'd30);
    chk("t4 ovf cleared", 32'(if2.ovf), 32'd0);

    // Reset beats load and en mid-count
    step(0, 1, 16, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("t5 counting at 17", 32'(if0.count), 32'd17);
    step(1, 1, 9, 1, 1);
    chk("t5 reset count", 32'(if0.count), 32'd0);
    chk("t5 reset ovf", 32'(if0.ovf), 32'd0);
    chk("t5 reset udf", 32'(if0.udf), 32'd0);
    step(0, 0, 0, 1, 1);
    chk("t5 resume", 32'(if0.count), 32'd1);

    // Random traffic, checked every cycle by the model process
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 31)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    step(0, 0, 0, 0, 1);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
